// File: rtl/display_pkg.sv
// Shared constants and helpers for the 4-digit seven-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one adjust+shift per cycle, DATA_W cycles
// per conversion. Digits hold their value once the counter reaches zero.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mag,
    output logic              done,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sh;
    logic [11:0]       bcd;
    logic [11:0]       bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            sh  <= '0;
            bcd <= '0;
        end else if (start) begin
            cnt <= CNT_W'(DATA_W);
            sh  <= mag;
            bcd <= '0;
        end else if (cnt != '0) begin
            bcd <= {bcd_adj[10:0], sh[DATA_W-1]};
            sh  <= {sh[DATA_W-2:0], 1'b0};
            cnt <= cnt - 1'b1;
        end
    end

    // Asserted during the final shift so the controller can leave CONV on that edge.
    assign done     = (cnt == CNT_W'(1));
    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/display_scan_controller.sv
// Captures an ALU result, converts it to sign + 3 BCD digits and scans the
// committed value across a 4-digit multiplexed seven-segment display.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] result,
    input  logic              is_signed,
    output logic              busy,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int unsigned RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]        state;
    logic              start;
    logic              neg_in;
    logic              neg_r;
    logic [DATA_W-1:0] mag_in;
    logic              conv_done;
    logic [3:0]        bcd_h;
    logic [3:0]        bcd_t;
    logic [3:0]        bcd_o;

    logic [3:0]        disp_h;
    logic [3:0]        disp_t;
    logic [3:0]        disp_o;
    logic              disp_neg;

    logic [RC_W-1:0]   rc;
    digit_idx_t        idx;
    logic [6:0]        seg_next;
    logic              blank_h;
    logic              blank_t;

    // Magnitude of a negative two's-complement value, wrapping so -2^(W-1) maps to 2^(W-1).
    assign neg_in = is_signed && result[DATA_W-1];
    assign mag_in = neg_in ? (-result) : result;
    assign start  = load && (state == ST_IDLE);

    bin_to_bcd_seq #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mag      (mag_in),
        .done     (conv_done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            neg_r    <= 1'b0;
            disp_h   <= '0;
            disp_t   <= '0;
            disp_o   <= '0;
            disp_neg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        neg_r <= neg_in;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_h   <= bcd_h;
                    disp_t   <= bcd_t;
                    disp_o   <= bcd_o;
                    disp_neg <= neg_r;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    assign blank_h = (BLANK_LZ != 0) && (disp_h == 4'd0);
    assign blank_t = blank_h && (disp_t == 4'd0);

    always_comb begin
        seg_next = SEG_BLANK;
        case (idx)
            2'd0: seg_next = bcd_to_seg(disp_o);
            2'd1: seg_next = blank_t ? SEG_BLANK : bcd_to_seg(disp_t);
            2'd2: seg_next = blank_h ? SEG_BLANK : bcd_to_seg(disp_h);
            2'd3: seg_next = disp_neg ? SEG_MINUS : SEG_BLANK;
            default: seg_next = SEG_BLANK;
        endcase
    end

    // an and seg are both registered from idx so anode and cathode switch together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rc  <= '0;
            idx <= '0;
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            if (rc == RC_W'(REFRESH_DIV - 1)) begin
                rc  <= '0;
                idx <= idx + 2'd1;
            end else begin
                rc <= rc + 1'b1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV=4, DATA_W=8;
// a second instance with BLANK_LZ=0 covers the leading-zero display.
module tb_display_scan_controller;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic       is_signed = 1'b0;
    logic [7:0] result = 8'h00;

    logic       busy, dp, busy2, dp2;
    logic [3:0] an, an2;
    logic [6:0] seg, seg2;

    int total = 0;
    int bad = 0;

    logic [6:0] cap  [4];
    logic [6:0] cap2 [4];
    logic [3:0] an_exp [4];

    always #5 clk = ~clk;

    display_scan_controller #(
        .DATA_W      (8),
        .REFRESH_DIV (4),
        .BLANK_LZ    (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .result    (result),
        .is_signed (is_signed),
        .busy      (busy),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    display_scan_controller #(
        .DATA_W      (8),
        .REFRESH_DIV (4),
        .BLANK_LZ    (0)
    ) dut_lz (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .result    (result),
        .is_signed (is_signed),
        .busy      (busy2),
        .an        (an2),
        .seg       (seg2),
        .dp        (dp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_frame();
        for (int i = 0; i < 4; i++) begin
            cap[i]  = 'x;
            cap2[i] = 'x;
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            case (an)
                4'b1110: cap[0] = seg;
                4'b1101: cap[1] = seg;
                4'b1011: cap[2] = seg;
                4'b0111: cap[3] = seg;
                default: ;
            endcase
            case (an2)
                4'b1110: cap2[0] = seg2;
                4'b1101: cap2[1] = seg2;
                4'b1011: cap2[2] = seg2;
                4'b0111: cap2[3] = seg2;
                default: ;
            endcase
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        capture_frame();
        check({tag, ".d3"}, cap[3], e3);
        check({tag, ".d2"}, cap[2], e2);
        check({tag, ".d1"}, cap[1], e1);
        check({tag, ".d0"}, cap[0], e0);
    endtask

    task automatic do_load(input string tag, input logic [7:0] r, input logic s);
        int n;
        result    = r;
        is_signed = s;
        load      = 1'b1;
        tick();
        load = 1'b0;
        check({tag, ".busy_rise"}, busy, 1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, ".busy_cycles"}, n, 9);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        an_exp[0] = 4'b1110;
        an_exp[1] = 4'b1101;
        an_exp[2] = 4'b1011;
        an_exp[3] = 4'b0111;

        reset_n = 1'b0;
        repeat (3) tick();
        check("rst.an", an, 4'b1111);
        check("rst.seg", seg, 7'h7F);
        check("rst.busy", busy, 0);
        check("rst.dp", dp, 1);
        check("rst.an_lz", an2, 4'b1111);

        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("scan.an%0d", i), an, an_exp[i/4]);
            check($sformatf("scan.seg%0d", i), seg, (i < 4) ? S0 : BL);
        end

        do_load("ld7B", 8'h7B, 1'b1);
        check_frame("f123", BL, S1, S2, S3);

        do_load("ld80s", 8'h80, 1'b1);
        check_frame("fm128", MI, S1, S2, S8);

        do_load("ld80u", 8'h80, 1'b0);
        check_frame("f128", BL, S1, S2, S8);

        do_load("ldF6", 8'hF6, 1'b1);
        check_frame("fm10", MI, BL, S1, S0);

        do_load("ld05", 8'h05, 1'b0);
        check_frame("f5", BL, BL, BL, S5);
        check("f005.d3", cap2[3], BL);
        check("f005.d2", cap2[2], S0);
        check("f005.d1", cap2[1], S0);
        check("f005.d0", cap2[0], S5);

        do_load("ldFFs", 8'hFF, 1'b1);
        check_frame("fm1", MI, BL, BL, S1);

        // Loads during CONV and during COMMIT must be dropped.
        result    = 8'h7B;
        is_signed = 1'b1;
        load      = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 3 || n == 9) begin
                load      = 1'b1;
                result    = 8'h05;
                is_signed = 1'b0;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        check("ign.busy_cycles", n, 9);
        tick();
        check("ign.no_requeue", busy, 0);
        tick();
        check_frame("fign", BL, S1, S2, S3);

        do_load("ldF6b", 8'hF6, 1'b1);
        result    = 8'h7B;
        is_signed = 1'b1;
        load      = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        check("abort.busy_pre", busy, 1);
        reset_n = 1'b0;
        tick();
        check("abort.busy", busy, 0);
        check("abort.an", an, 4'b1111);
        check("abort.seg", seg, 7'h7F);
        tick();
        reset_n = 1'b1;
        check_frame("fabort", BL, BL, BL, S0);
        repeat (20) tick();
        check("abort.busy_late", busy, 0);
        check_frame("fabort_late", BL, BL, BL, S0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
